// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: per-source mask, level/edge pending, lowest-index priority,
// and an IDLE/REQ/SERV handshake with the CPU. Define IRQ_EDGE_EN to build in edge mode and PEND W1C.
module irq_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic            ie,
  input  logic            exl,
  input  logic            ack,
  input  logic            eoi,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq,
  output logic [NSRC-1:0] cause_ip,
  output logic [2:0]      cur_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SERV = 2'd2;

  localparam logic [1:0] A_MASK   = 2'd0;
  localparam logic [1:0] A_PEND   = 2'd1;
  localparam logic [1:0] A_MODE   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic [1:0]      state;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] pend_nxt;
  logic [NSRC-1:0] mode;
  logic [2:0]      req_id;
  logic            accept;

  // Write-data bits above the source count have no backing storage.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:NSRC];

  assign cause_ip = pend & mask;
  assign accept   = (state == REQ) && ack;

  // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    req_id = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cause_ip[i]) req_id = 3'(i);
    end
  end

`ifdef IRQ_EDGE_EN
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] edge_set;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] acc_clr;

  always_comb begin
    acc_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (accept && (req_id == 3'(i))) acc_clr[i] = 1'b1;
    end
  end

  assign edge_set = src & ~src_q;
  assign w1c      = (we && (addr == A_PEND)) ? wdata[NSRC-1:0] : '0;
  // Edge bits: a fresh edge beats a clear landing in the same cycle. Level bits follow src.
  assign pend_nxt = (mode & (edge_set | (pend & ~(w1c | acc_clr)))) | (~mode & src);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q <= '0;
      mode  <= '0;
    end else begin
      src_q <= src;
      if (we && (addr == A_MODE)) mode <= wdata[NSRC-1:0];
    end
  end
`else
  assign mode     = '0;
  assign pend_nxt = src;
`endif

  // NOTE: state is updated with non-blocking assignments only, and the reset term is asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask <= '0;
      pend <= '0;
    end else begin
      pend <= pend_nxt;
      if (we && (addr == A_MASK)) mask <= wdata[NSRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      irq    <= 1'b0;
      cur_id <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if ((cause_ip != '0) && ie && !exl) begin
            state <= REQ;
            irq   <= 1'b1;
          end
        end
        REQ: begin
          // Acceptance takes precedence over a withdrawal seen in the same cycle.
          if (ack) begin
            state  <= SERV;
            irq    <= 1'b0;
            cur_id <= req_id;
          end else if (cause_ip == '0) begin
            state <= IDLE;
            irq   <= 1'b0;
          end
        end
        SERV: begin
          if (eoi) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      A_MASK:   rdata = {{(32 - NSRC){1'b0}}, mask};
      A_PEND:   rdata = {{(32 - NSRC){1'b0}}, pend};
      A_MODE:   rdata = {{(32 - NSRC){1'b0}}, mode};
      A_STATUS: rdata = {21'd0, req_id, 1'b0, cur_id, 2'b00, state};
      default:  rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a vector table for the level-mode handshake, plus hand-written
// sequences for asynchronous reset in SERV and (with IRQ_EDGE_EN) edge capture and PEND W1C.
module tb_irq_ctrl;

  localparam int NSRC = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] src;
  logic            ie, exl, ack, eoi, we;
  logic [1:0]      addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            irq;
  logic [NSRC-1:0] cause_ip;
  logic [2:0]      cur_id;

  int n_cmp  = 0;
  int n_fail = 0;

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .ie       (ie),
    .exl      (exl),
    .ack      (ack),
    .eoi      (eoi),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq),
    .cause_ip (cause_ip),
    .cur_id   (cur_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            we;
    logic [1:0]      addr;
    logic [31:0]     wdata;
    logic [NSRC-1:0] src;
    logic            ie;
    logic            exl;
    logic            ack;
    logic            eoi;
    logic            e_irq;
    logic [NSRC-1:0] e_cause;
    logic [2:0]      e_cur;
    logic [31:0]     e_rdata;
  } vec_t;

  localparam int NVEC = 21;
  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           we    addr  wdata   src    ie    exl   ack   eoi   irq   cause  cur   rdata
    tbl[0]  = '{1'b1, 2'd0, 32'h3F, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd0, 32'h3F};
    tbl[1]  = '{1'b0, 2'd3, 32'h00, 6'h08, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h08, 3'd0, 32'h300};
    tbl[2]  = '{1'b0, 2'd3, 32'h00, 6'h08, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h08, 3'd0, 32'h301};
    tbl[3]  = '{1'b0, 2'd3, 32'h00, 6'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h08, 3'd3, 32'h332};
    tbl[4]  = '{1'b0, 2'd3, 32'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd3, 32'h032};
    tbl[5]  = '{1'b0, 2'd3, 32'h00, 6'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h12, 3'd3, 32'h130};
    tbl[6]  = '{1'b0, 2'd3, 32'h00, 6'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h12, 3'd3, 32'h131};
    tbl[7]  = '{1'b0, 2'd3, 32'h00, 6'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h10, 3'd1, 32'h412};
    tbl[8]  = '{1'b0, 2'd3, 32'h00, 6'h10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h10, 3'd1, 32'h410};
    tbl[9]  = '{1'b0, 2'd3, 32'h00, 6'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h10, 3'd1, 32'h411};
    // Withdrawal by masking while in REQ.
    tbl[10] = '{1'b1, 2'd0, 32'h00, 6'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 3'd1, 32'h00};
    tbl[11] = '{1'b0, 2'd3, 32'h00, 6'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 3'd1, 32'h010};
    tbl[12] = '{1'b1, 2'd0, 32'h3F, 6'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h10, 3'd1, 32'h3F};
    tbl[13] = '{1'b0, 2'd3, 32'h00, 6'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h10, 3'd1, 32'h411};
    // ack in the same cycle as the masking write: ack wins.
    tbl[14] = '{1'b1, 2'd0, 32'h00, 6'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 3'd4, 32'h00};
    tbl[15] = '{1'b0, 2'd3, 32'h00, 6'h10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 3'd4, 32'h040};
    // ie / exl gating.
    tbl[16] = '{1'b1, 2'd0, 32'h3F, 6'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h10, 3'd4, 32'h3F};
    tbl[17] = '{1'b0, 2'd3, 32'h00, 6'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h10, 3'd4, 32'h440};
    tbl[18] = '{1'b0, 2'd3, 32'h00, 6'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h10, 3'd4, 32'h440};
    tbl[19] = '{1'b0, 2'd3, 32'h00, 6'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h10, 3'd4, 32'h441};
    tbl[20] = '{1'b0, 2'd3, 32'h00, 6'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h10, 3'd4, 32'h442};

    rst = 1'b0; src = '0; ie = 1'b0; exl = 1'b0; ack = 1'b0; eoi = 1'b0;
    we = 1'b0; addr = 2'd3; wdata = '0;
    #12;
    check("reset irq", {31'd0, irq}, 32'd0);
    check("reset status", rdata, 32'd0);
    check("reset cur_id", {29'd0, cur_id}, 32'd0);
    addr = 2'd0;
    #1;
    check("reset mask", rdata, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wdata; src = tbl[i].src;
      ie = tbl[i].ie; exl = tbl[i].exl; ack = tbl[i].ack; eoi = tbl[i].eoi;
      tick();
      check($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, tbl[i].e_irq});
      check($sformatf("vec%0d cause_ip", i), {26'd0, cause_ip}, {26'd0, tbl[i].e_cause});
      check($sformatf("vec%0d cur_id", i), {29'd0, cur_id}, {29'd0, tbl[i].e_cur});
      check($sformatf("vec%0d rdata", i), rdata, tbl[i].e_rdata);
    end
    we = 1'b0; ack = 1'b0; eoi = 1'b0; addr = 2'd3;

    // Asynchronous reset while in SERV, checked before the next clock edge.
    #1;
    rst = 1'b0;
    #1;
    check("async rst irq", {31'd0, irq}, 32'd0);
    check("async rst status", rdata, 32'd0);
    addr = 2'd0;
    #1;
    check("async rst mask", rdata, 32'd0);
    rst = 1'b1;
    addr = 2'd3;
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("eoi after rst status", rdata, 32'd0);
    check("eoi after rst irq", {31'd0, irq}, 32'd0);

`ifdef IRQ_EDGE_EN
    src = '0;
    tick();
    we = 1'b1; addr = 2'd0; wdata = 32'h3F;
    tick();
    addr = 2'd2; wdata = 32'h01;
    tick();
    check("edge mode readback", rdata, 32'h01);
    we = 1'b0; addr = 2'd1; src = 6'h01;
    tick();
    check("edge pend latched", rdata, 32'h01);
    src = 6'h00;
    tick();
    check("edge pend held", rdata, 32'h01);
    check("edge irq", {31'd0, irq}, 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("edge ack clears pend", rdata, 32'h00);
    check("edge ack irq", {31'd0, irq}, 32'd0);
    check("edge ack cur_id", {29'd0, cur_id}, 32'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    we = 1'b1; addr = 2'd0; wdata = 32'h00;
    tick();
    we = 1'b0; addr = 2'd1; src = 6'h01;
    tick();
    src = 6'h00;
    tick();
    src = 6'h01; we = 1'b1; wdata = 32'h01;
    tick();
    check("w1c vs new edge", rdata, 32'h01);
    tick();
    we = 1'b0;
    check("w1c clears", rdata, 32'h00);
`else
    we = 1'b1; addr = 2'd2; wdata = 32'h3F;
    tick();
    we = 1'b0;
    check("mode reads zero", rdata, 32'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
